glitch_seq_wb: RTL and testbench

//  Wishbone-slave glitch sequencer. Software queues (delay, width) pulse descriptors into an internal FIFO, then arms the block.
//  An on-chip sequencer plays the descriptors back-to-back on glitch_o, starting immediately or on an external trigger edge.
//  The block runs in a single clock domain, is parametrised in descriptor widths and queue depth, and adds abort, flush, overflow and done-IRQ.

---
 rtl/glitch_seq_wb.sv | 225 ++++++++++++++++++++++
 tb/tb_glitch_seq_wb.sv | 292 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/glitch_seq_wb.sv
// Wishbone-slave glitch sequencer: software queues (delay, width) descriptors
// into a FIFO, then arms the block, which plays them back on glitch_o either
// immediately or after a synchronised rising edge on trig_i.
module glitch_seq_wb #(
  parameter int DELAY_W    = 16,
  parameter int WIDTH_W    = 16,
  parameter int FIFO_DEPTH = 16,
  parameter int CNT_W      = 5
) (
  input  logic       clk_i,
  input  logic       rst_i,
  input  logic [3:0] adr_i,
  input  logic [7:0] dat_i,
  output logic [7:0] dat_o,
  input  logic       we_i,
  input  logic       stb_i,
  output logic       ack_o,
  input  logic       trig_i,
  output logic       glitch_o,
  output logic       busy_o,
  output logic       irq_o
);

  localparam int PTR_W = CNT_W - 1;

  typedef enum logic [2:0] {IDLE, WAIT_TRIG, LOAD, DELAY, PULSE} state_t;

  state_t               state_q, state_d;
  logic [31:0]          staging_q;
  logic                 trig_mode_q;
  logic                 ovf_q;
  logic [31:0]          fifo_mem [FIFO_DEPTH];
  logic [PTR_W-1:0]     wr_ptr_q, rd_ptr_q;
  logic [CNT_W-1:0]     level_q;
  logic [DELAY_W-1:0]   del_cnt_q;
  logic [WIDTH_W-1:0]   wid_cnt_q;
  logic                 trig_s1_q, trig_s2_q, trig_s3_q;
  logic                 irq_set;
  logic [7:0]           rd_data;

  // Bus request decode: a transfer is accepted in the cycle ack is being raised.
  logic wr_cyc, rd_cyc, ctrl_wr, abort_cmd, arm_cmd, flush_cmd, ovf_clr, push_req;
  assign wr_cyc    = stb_i & ~ack_o & we_i;
  assign rd_cyc    = stb_i & ~ack_o & ~we_i;
  assign ctrl_wr   = wr_cyc & (adr_i == 4'd0);
  assign abort_cmd = ctrl_wr & dat_i[1];
  assign arm_cmd   = ctrl_wr & dat_i[0];
  assign flush_cmd = ctrl_wr & dat_i[3] & (state_q == IDLE);
  assign ovf_clr   = wr_cyc & (adr_i == 4'd1) & dat_i[3];
  assign push_req  = wr_cyc & (adr_i == 4'd7);

  // FIFO status; a pop in the same cycle frees room for a push to a full queue.
  logic fifo_empty, fifo_full, pop, push_ok, ovf_set, more_after_pop, more_now, trig_rise;
  logic [31:0]        head;
  logic [DELAY_W-1:0] head_d;
  logic [WIDTH_W-1:0] head_w;
  assign fifo_empty     = (level_q == '0);
  assign fifo_full      = (level_q == CNT_W'(FIFO_DEPTH));
  assign pop            = (state_q == LOAD);
  assign push_ok        = push_req & (~fifo_full | pop);
  assign ovf_set        = push_req & ~push_ok;
  assign head           = fifo_mem[rd_ptr_q];
  assign head_d         = head[DELAY_W-1:0];
  assign head_w         = head[31:DELAY_W];
  assign more_after_pop = (level_q != CNT_W'(1)) | push_ok;
  assign more_now       = ~fifo_empty | push_ok;
  assign trig_rise      = trig_s2_q & ~trig_s3_q;
  assign busy_o         = (state_q != IDLE);

  // Bus handshake and registered read data, zero whenever ack is low.
  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      ack_o <= 1'b0;
      dat_o <= 8'h00;
    end else begin
      ack_o <= stb_i & ~ack_o;
      dat_o <= rd_cyc ? rd_data : 8'h00;
    end
  end

  // Read multiplexer over the register map; unmapped addresses read as zero.
  always_comb begin
    rd_data = 8'h00;
    case (adr_i)
      4'd0:                      rd_data = {5'b0, trig_mode_q, 2'b0};
      4'd1:                      rd_data = {3'b0, busy_o, ovf_q, fifo_full, fifo_empty, ~busy_o};
      4'd2:                      rd_data = {{(8-CNT_W){1'b0}}, level_q};
      4'd4, 4'd5, 4'd6, 4'd7:    rd_data = staging_q[{adr_i[1:0], 3'b000} +: 8];
      default:                   rd_data = 8'h00;
    endcase
  end

  // Software-visible configuration: staging bytes, trigger mode and sticky overflow.
  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      staging_q   <= 32'h0;
      trig_mode_q <= 1'b0;
      ovf_q       <= 1'b0;
    end else begin
      if (wr_cyc && adr_i[3:2] == 2'b01)
        staging_q[{adr_i[1:0], 3'b000} +: 8] <= dat_i;
      if (ctrl_wr)
        trig_mode_q <= dat_i[2];
      if (ovf_set)
        ovf_q <= 1'b1;
      else if (ovf_clr)
        ovf_q <= 1'b0;
    end
  end

  // Descriptor storage; the pushed word uses the byte-3 value being written now.
  always_ff @(posedge clk_i) begin
    if (push_ok)
      fifo_mem[wr_ptr_q] <= {dat_i, staging_q[23:0]};
  end

  // Queue pointers and occupancy; flush clears them while the sequencer is idle.
  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      level_q  <= '0;
    end else if (flush_cmd) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      level_q  <= '0;
    end else begin
      if (push_ok) wr_ptr_q <= wr_ptr_q + 1'b1;
      if (pop)     rd_ptr_q <= rd_ptr_q + 1'b1;
      case ({push_ok, pop})
        2'b10:   level_q <= level_q + 1'b1;
        2'b01:   level_q <= level_q - 1'b1;
        default: level_q <= level_q;
      endcase
    end
  end

  // Two-flop synchroniser for trig_i plus one extra stage for edge detection.
  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      trig_s1_q <= 1'b0;
      trig_s2_q <= 1'b0;
      trig_s3_q <= 1'b0;
    end else begin
      trig_s1_q <= trig_i;
      trig_s2_q <= trig_s1_q;
      trig_s3_q <= trig_s2_q;
    end
  end

  // Sequencer state register with registered glitch and irq outputs.
  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      state_q  <= IDLE;
      glitch_o <= 1'b0;
      irq_o    <= 1'b0;
    end else begin
      state_q  <= state_d;
      glitch_o <= (state_d == PULSE);
      irq_o    <= irq_set;
    end
  end

  // Next-state logic; abort overrides everything, including a concurrent arm.
  always_comb begin
    state_d = state_q;
    irq_set = 1'b0;
    if (abort_cmd) begin
      state_d = IDLE;
    end else begin
      case (state_q)
        IDLE:
          if (arm_cmd && !fifo_empty && !dat_i[3])
            state_d = dat_i[2] ? WAIT_TRIG : LOAD;
        WAIT_TRIG:
          if (trig_rise) state_d = LOAD;
        LOAD:
          if (head_d != '0)        state_d = DELAY;
          else if (head_w != '0)   state_d = PULSE;
          else if (more_after_pop) state_d = LOAD;
          else begin
            state_d = IDLE;
            irq_set = 1'b1;
          end
        DELAY:
          if (del_cnt_q == DELAY_W'(1)) begin
            if (wid_cnt_q != '0) state_d = PULSE;
            else if (more_now)   state_d = LOAD;
            else begin
              state_d = IDLE;
              irq_set = 1'b1;
            end
          end
        PULSE:
          if (wid_cnt_q == WIDTH_W'(1)) begin
            if (more_now) state_d = LOAD;
            else begin
              state_d = IDLE;
              irq_set = 1'b1;
            end
          end
        default: state_d = IDLE;
      endcase
    end
  end

  // Delay and width counters: loaded from the head in LOAD, counted down after.
  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      del_cnt_q <= '0;
      wid_cnt_q <= '0;
    end else begin
      case (state_q)
        LOAD: begin
          del_cnt_q <= head_d;
          wid_cnt_q <= head_w;
        end
        DELAY:   del_cnt_q <= del_cnt_q - 1'b1;
        PULSE:   wid_cnt_q <= wid_cnt_q - 1'b1;
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_glitch_seq_wb.sv
// Directed self-checking bench for glitch_seq_wb.
module tb_glitch_seq_wb;

  logic       clk_i = 1'b0;
  logic       rst_i;
  logic [3:0] adr_i;
  logic [7:0] dat_i;
  logic [7:0] dat_o;
  logic       we_i;
  logic       stb_i;
  logic       ack_o;
  logic       trig_i;
  logic       glitch_o;
  logic       busy_o;
  logic       irq_o;

  int errorCount = 0;
  int checkCount = 0;
  int cycCount = 0;
  int lastAckCyc = 0;

  // Pulse/irq monitor bookkeeping
  int riseCyc [64];
  int widthArr [64];
  int nRise = 0;
  int irqCount = 0;
  int lastIrqCyc = 0;
  logic prevG = 1'b0;

  glitch_seq_wb dut (
    .clk_i    (clk_i),
    .rst_i    (rst_i),
    .adr_i    (adr_i),
    .dat_i    (dat_i),
    .dat_o    (dat_o),
    .we_i     (we_i),
    .stb_i    (stb_i),
    .ack_o    (ack_o),
    .trig_i   (trig_i),
    .glitch_o (glitch_o),
    .busy_o   (busy_o),
    .irq_o    (irq_o)
  );

  // Free-running clock
  always #5 clk_i = ~clk_i;

  // Cycle counter: after rising edge k it holds k
  always @(posedge clk_i) cycCount <= cycCount + 1;

  // Records the cycle of every glitch rise, its length, and irq pulses
  always @(negedge clk_i) begin
    if (glitch_o && !prevG && nRise < 64) riseCyc[nRise] = cycCount;
    if (!glitch_o && prevG && nRise < 64) begin
      widthArr[nRise] = cycCount - riseCyc[nRise];
      nRise = nRise + 1;
    end
    if (irq_o) begin
      irqCount   = irqCount + 1;
      lastIrqCyc = cycCount;
    end
    prevG = glitch_o;
  end

  // Single comparison point
  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checkCount = checkCount + 1;
    if (obs !== exp) begin
      errorCount = errorCount + 1;
      $display("[TB] FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Ensure ack is low before starting a new transfer
  task automatic busIdle();
    if (ack_o) begin
      @(posedge clk_i);
      #1;
    end
  endtask

  // Bus write; returns 1ns after the ack edge with stb released
  task automatic applyStimulus(input logic [3:0] a, input logic [7:0] d);
    busIdle();
    adr_i = a; dat_i = d; we_i = 1'b1; stb_i = 1'b1;
    for (int i = 0; i < 4; i++) begin
      @(posedge clk_i);
      #1;
      if (ack_o) break;
    end
    checkOutput("wr_ack", 32'(ack_o), 32'd1);
    lastAckCyc = cycCount;
    stb_i = 1'b0; we_i = 1'b0;
  endtask

  // Bus read
  task automatic busRead(input logic [3:0] a, output logic [7:0] d);
    busIdle();
    adr_i = a; we_i = 1'b0; stb_i = 1'b1;
    for (int i = 0; i < 4; i++) begin
      @(posedge clk_i);
      #1;
      if (ack_o) break;
    end
    checkOutput("rd_ack", 32'(ack_o), 32'd1);
    d = dat_o;
    stb_i = 1'b0;
  endtask

  task automatic readCheck(input string tag, input logic [3:0] a, input logic [7:0] exp);
    logic [7:0] d;
    busRead(a, d);
    checkOutput(tag, 32'(d), 32'(exp));
  endtask

  task automatic pushDesc(input logic [15:0] dly, input logic [15:0] wid);
    applyStimulus(4'd4, dly[7:0]);
    applyStimulus(4'd5, dly[15:8]);
    applyStimulus(4'd6, wid[7:0]);
    applyStimulus(4'd7, wid[15:8]);
  endtask

  task automatic waitCycles(input int n);
    repeat (n) @(posedge clk_i);
    #1;
  endtask

  task automatic checkAllLow(input string tag);
    checkOutput({tag, "_ack"},    32'(ack_o),    32'd0);
    checkOutput({tag, "_dat"},    32'(dat_o),    32'd0);
    checkOutput({tag, "_glitch"}, 32'(glitch_o), 32'd0);
    checkOutput({tag, "_busy"},   32'(busy_o),   32'd0);
    checkOutput({tag, "_irq"},    32'(irq_o),    32'd0);
  endtask

  initial begin
    int base, irqBase, armCyc, trigCyc;
    rst_i = 1'b0; adr_i = 4'd0; dat_i = 8'h00; we_i = 1'b0; stb_i = 1'b0; trig_i = 1'b0;

    // Reset state
    repeat (3) @(posedge clk_i);
    #1;
    checkAllLow("rst");
    @(negedge clk_i);
    rst_i = 1'b1;
    @(posedge clk_i);
    #1;
    readCheck("rst_status", 4'd1, 8'h03);
    readCheck("rst_level",  4'd2, 8'h00);
    readCheck("rst_ctrl",   4'd0, 8'h00);

    // Unmapped addresses
    applyStimulus(4'd9, 8'hFF);
    readCheck("unmapped9", 4'd9, 8'h00);
    readCheck("unmapped3", 4'd3, 8'h00);

    // T1: single descriptor D=3 W=2
    $display("[TB] T1 single descriptor");
    pushDesc(16'd3, 16'd2);
    readCheck("t1_level1", 4'd2, 8'h01);
    readCheck("t1_stage0", 4'd4, 8'h03);
    base = nRise; irqBase = irqCount;
    applyStimulus(4'd0, 8'h01);
    armCyc = lastAckCyc;
    waitCycles(12);
    checkOutput("t1_nrise", 32'(nRise - base), 32'd1);
    checkOutput("t1_rise",  32'(riseCyc[base]), 32'(armCyc + 4));
    checkOutput("t1_width", 32'(widthArr[base]), 32'd2);
    checkOutput("t1_irqn",  32'(irqCount - irqBase), 32'd1);
    checkOutput("t1_irqc",  32'(lastIrqCyc), 32'(armCyc + 6));
    readCheck("t1_level0", 4'd2, 8'h00);
    readCheck("t1_status", 4'd1, 8'h03);

    // T2: chained descriptors with a null terminator
    $display("[TB] T2 chained descriptors");
    pushDesc(16'd0, 16'd1);
    pushDesc(16'd2, 16'd3);
    pushDesc(16'd0, 16'd0);
    readCheck("t2_level3", 4'd2, 8'h03);
    base = nRise; irqBase = irqCount;
    applyStimulus(4'd0, 8'h01);
    armCyc = lastAckCyc;
    waitCycles(15);
    checkOutput("t2_nrise",  32'(nRise - base), 32'd2);
    checkOutput("t2_rise1",  32'(riseCyc[base]), 32'(armCyc + 1));
    checkOutput("t2_width1", 32'(widthArr[base]), 32'd1);
    checkOutput("t2_rise2",  32'(riseCyc[base + 1]), 32'(armCyc + 5));
    checkOutput("t2_width2", 32'(widthArr[base + 1]), 32'd3);
    checkOutput("t2_irqn",   32'(irqCount - irqBase), 32'd1);
    checkOutput("t2_irqc",   32'(lastIrqCyc), 32'(armCyc + 9));
    readCheck("t2_level0", 4'd2, 8'h00);

    // T3: triggered start, flush ignored while busy
    $display("[TB] T3 trigger mode");
    pushDesc(16'd2, 16'd1);
    base = nRise; irqBase = irqCount;
    applyStimulus(4'd0, 8'h05);
    waitCycles(5);
    readCheck("t3_status", 4'd1, 8'h10);
    readCheck("t3_ctrl",   4'd0, 8'h04);
    applyStimulus(4'd0, 8'h0C);
    readCheck("t3_noflush", 4'd2, 8'h01);
    checkOutput("t3_norise", 32'(nRise - base), 32'd0);
    checkOutput("t3_busy",   32'(busy_o), 32'd1);
    waitCycles(1);
    trig_i = 1'b1;
    trigCyc = cycCount;
    waitCycles(12);
    trig_i = 1'b0;
    checkOutput("t3_nrise", 32'(nRise - base), 32'd1);
    checkOutput("t3_rise",  32'(riseCyc[base]), 32'(trigCyc + 6));
    checkOutput("t3_irqc",  32'(lastIrqCyc), 32'(trigCyc + 7));
    checkOutput("t3_irqn",  32'(irqCount - irqBase), 32'd1);
    applyStimulus(4'd0, 8'h00);

    // T4: overflow, W1C and flush
    $display("[TB] T4 overflow");
    applyStimulus(4'd4, 8'h11);
    applyStimulus(4'd5, 8'h22);
    applyStimulus(4'd6, 8'h33);
    for (int i = 0; i < 17; i++) applyStimulus(4'd7, 8'h44);
    readCheck("t4_level16", 4'd2, 8'h10);
    readCheck("t4_status",  4'd1, 8'h0D);
    applyStimulus(4'd1, 8'h08);
    readCheck("t4_w1c", 4'd1, 8'h05);
    applyStimulus(4'd0, 8'h08);
    readCheck("t4_flush",  4'd2, 8'h00);
    readCheck("t4_st_ok",  4'd1, 8'h03);
    readCheck("t4_staging", 4'd6, 8'h33);

    // T5: abort during a long pulse; abort beats arm
    $display("[TB] T5 abort");
    pushDesc(16'd0, 16'd100);
    pushDesc(16'd1, 16'd1);
    irqBase = irqCount;
    applyStimulus(4'd0, 8'h01);
    waitCycles(10);
    checkOutput("t5_glitch_hi", 32'(glitch_o), 32'd1);
    applyStimulus(4'd0, 8'h02);
    checkOutput("t5_glitch_lo", 32'(glitch_o), 32'd0);
    checkOutput("t5_busy_lo",   32'(busy_o), 32'd0);
    waitCycles(5);
    checkOutput("t5_noirq", 32'(irqCount - irqBase), 32'd0);
    readCheck("t5_level", 4'd2, 8'h01);
    applyStimulus(4'd0, 8'h03);
    checkOutput("t5_abort_arm", 32'(busy_o), 32'd0);
    waitCycles(3);
    checkOutput("t5_abort_arm2", 32'(glitch_o), 32'd0);
    applyStimulus(4'd0, 8'h08);
    readCheck("t5_flush", 4'd2, 8'h00);

    // T6: asynchronous reset mid-delay and mid-pulse
    $display("[TB] T6 async reset");
    pushDesc(16'd10, 16'd5);
    pushDesc(16'd1, 16'd1);
    applyStimulus(4'd0, 8'h01);
    waitCycles(3);
    checkOutput("t6_busy_pre", 32'(busy_o), 32'd1);
    #2 rst_i = 1'b0;
    #1;
    checkAllLow("t6_dly");
    @(negedge clk_i);
    rst_i = 1'b1;
    @(posedge clk_i);
    #1;
    readCheck("t6_level",  4'd2, 8'h00);
    readCheck("t6_status", 4'd1, 8'h03);
    pushDesc(16'd0, 16'd50);
    applyStimulus(4'd0, 8'h01);
    waitCycles(5);
    checkOutput("t6_pulse_pre", 32'(glitch_o), 32'd1);
    #2 rst_i = 1'b0;
    #1;
    checkOutput("t6_pulse_drop", 32'(glitch_o), 32'd0);
    checkOutput("t6_pulse_busy", 32'(busy_o), 32'd0);
    @(negedge clk_i);
    rst_i = 1'b1;
    waitCycles(2);
    readCheck("t6_status2", 4'd1, 8'h03);

    $display("Result: errors=%0d of %0d checks", errorCount, checkCount);
    $finish;
  end

  // Global time limit so the run always ends
  initial begin
    #200000;
    $display("[TB] FAIL timeout: got running expected finished");
    $fatal(1, "[TB] timeout");
  end

endmodule
